// File: rtl/serial_flow_alu.sv
// Bit-serial add/subtract unit: LSB-first operand streams, one-cycle result latency,
// per-word carry/borrow and zero flags with a word_done strobe.
module serial_flow_alu #(
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W)
) (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  input  logic valid,
  input  logic mode,
  output logic outp,
  output logic outp_valid,
  output logic overflw,
  output logic zero,
  output logic word_done,
  output logic busy
);

  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             m;
  logic             za;

  logic first_bit;
  logic last_bit;
  logic me;
  logic ci;
  logic s;
  logic co;
  logic za_eff;

  // Mode and carry-in come straight from the port / zero on the first bit,
  // so a new word never depends on the previous one.
  always_comb begin
    first_bit = (cnt == '0);
    last_bit  = (cnt == CNT_W'(WORD_W - 1));
    me        = first_bit ? mode : m;
    ci        = first_bit ? 1'b0 : c;
    s         = line1 ^ line2 ^ ci;
    if (me)
      co = (~line1 & line2) | (~(line1 ^ line2) & ci);
    else
      co = (line1 & line2) | (ci & (line1 ^ line2));
    za_eff    = (first_bit | za) & ~s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      c          <= 1'b0;
      m          <= 1'b0;
      za         <= 1'b0;
      outp       <= 1'b0;
      outp_valid <= 1'b0;
      overflw    <= 1'b0;
      zero       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      outp_valid <= valid;
      word_done  <= 1'b0;
      if (valid) begin
        outp <= s;
        c    <= co;
        za   <= za_eff;
        if (first_bit)
          m <= mode;
        if (last_bit) begin
          cnt       <= '0;
          overflw   <= co;
          zero      <= za_eff;
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (cnt != '0);

endmodule
